// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: shared constants for the memory-mapped timer.
//   Register byte offsets inside the 32-byte window, and bit positions
//   of the CTRL and STATUS fields.
package mmio_timer_pkg;

  // Byte offsets within the register window (A[4:0], word aligned)
  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_PRESC   = 5'h04;
  localparam logic [4:0] OFF_COUNT   = 5'h08;
  localparam logic [4:0] OFF_CMP     = 5'h0C;
  localparam logic [4:0] OFF_STATUS  = 5'h10;
  localparam logic [4:0] OFF_CAPTURE = 5'h14;

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;

  // STATUS bit positions
  localparam int STAT_MATCH = 0;
  localparam int STAT_CAP   = 1;

endpackage

// File: rtl/mmio_timer_prescaler.sv
// timer_prescaler: divides the clock by (presc + 1) while enabled.
//   clk      : system clock
//   reset_n  : synchronous active-low reset
//   en       : count enable; when low the divider is held at 0
//   presc    : terminal value of the divider
//   presc_wr : restarts the divider from 0 (new prescale value written)
//   tick     : high in the cycle the divider sits on its terminal value
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               presc_wr,
  output logic               tick
);

  logic [PRESC_W-1:0] pre_cnt_r;

  // Tick is combinational so the counter can act on it in the same cycle.
  assign tick = en && (pre_cnt_r == presc);

  // Divider state: 0..presc, restarted by reset, disable or a prescale write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_cnt_r <= {PRESC_W{1'b0}};
    end else if (presc_wr || !en) begin
      pre_cnt_r <= {PRESC_W{1'b0}};
    end else if (pre_cnt_r == presc) begin
      pre_cnt_r <= {PRESC_W{1'b0}};
    end else begin
      pre_cnt_r <= pre_cnt_r + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit timer with compare/match IRQ.
//   Sits on the data-memory bus in parallel with RAM; RD is zero when the
//   window is not selected so it can be OR-ed with RAM read data.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   A       : byte address (A[1:0] ignored, word access only)
//   WE / RE : store / load strobes
//   WD / RD : store data / combinational load data
//   irq     : level interrupt, (MATCH [| CAP]) & IRQ_EN
// Optional build macro TIMER_CAPTURE_EN adds capture_in (asynchronous)
//   and a CAPTURE register at offset 0x14 with STATUS.CAP flag.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 10'h3E0,
  parameter int                PRESC_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] A,
  input  logic              WE,
  input  logic              RE,
  input  logic [31:0]       WD,
  output logic [31:0]       RD,
`ifdef TIMER_CAPTURE_EN
  input  logic              capture_in,
`endif
  output logic              irq
);

  logic               sel_s;
  logic [4:0]         off_s;
  logic               wr_ctrl_s, wr_presc_s, wr_count_s, wr_cmp_s, wr_status_s;
  logic               tick_s, step_s, hit_s;
  logic [31:0]        rd_mux_s;
  logic               cap_flag_s;
  logic [31:0]        capture_s;
  logic               unused_s;

  logic               ctrl_en_r, ctrl_auto_r, ctrl_irqen_r;
  logic [PRESC_W-1:0] presc_r;
  logic [31:0]        count_r;
  logic [31:0]        cmp_r;
  logic               match_r;

  assign unused_s = &{1'b0, A[1:0]};

  assign sel_s = (A[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]);
  assign off_s = {A[4:2], 2'b00};

  assign wr_ctrl_s   = sel_s && WE && (off_s == OFF_CTRL);
  assign wr_presc_s  = sel_s && WE && (off_s == OFF_PRESC);
  assign wr_count_s  = sel_s && WE && (off_s == OFF_COUNT);
  assign wr_cmp_s    = sel_s && WE && (off_s == OFF_CMP);
  assign wr_status_s = sel_s && WE && (off_s == OFF_STATUS);

  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (ctrl_en_r),
    .presc    (presc_r),
    .presc_wr (wr_presc_s),
    .tick     (tick_s)
  );

  // A CTRL store that clears EN suppresses the step on that same edge.
  assign step_s = tick_s && !(wr_ctrl_s && !WD[CTRL_EN]);
  assign hit_s  = step_s && (count_r == cmp_r);

  // CTRL register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_en_r    <= 1'b0;
      ctrl_auto_r  <= 1'b0;
      ctrl_irqen_r <= 1'b0;
    end else if (wr_ctrl_s) begin
      ctrl_en_r    <= WD[CTRL_EN];
      ctrl_auto_r  <= WD[CTRL_AUTO];
      ctrl_irqen_r <= WD[CTRL_IRQEN];
    end else begin
      ctrl_en_r    <= ctrl_en_r;
      ctrl_auto_r  <= ctrl_auto_r;
      ctrl_irqen_r <= ctrl_irqen_r;
    end
  end

  // PRESC and CMP registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_r <= {PRESC_W{1'b0}};
      cmp_r   <= 32'h0;
    end else begin
      presc_r <= wr_presc_s ? WD[PRESC_W-1:0] : presc_r;
      cmp_r   <= wr_cmp_s ? WD : cmp_r;
    end
  end

  // COUNT: a software store wins over the hardware increment/reload
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r <= 32'h0;
    end else if (wr_count_s) begin
      count_r <= WD;
    end else if (step_s) begin
      count_r <= (hit_s && ctrl_auto_r) ? 32'h0 : count_r + 32'h1;
    end else begin
      count_r <= count_r;
    end
  end

  // STATUS.MATCH: a hardware set wins over a write-1-to-clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      match_r <= 1'b0;
    end else if (hit_s) begin
      match_r <= 1'b1;
    end else if (wr_status_s && WD[STAT_MATCH]) begin
      match_r <= 1'b0;
    end else begin
      match_r <= match_r;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic        sync1_r, sync2_r, sync3_r;
  logic        cap_rise_s;
  logic        cap_r;
  logic [31:0] capture_r;

  // Two-flop synchronizer plus one delay stage for rising-edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= capture_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign cap_rise_s = sync2_r && !sync3_r;

  // CAPTURE latch and STATUS.CAP (set wins over write-1-to-clear)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      capture_r <= 32'h0;
      cap_r     <= 1'b0;
    end else if (cap_rise_s) begin
      capture_r <= count_r;
      cap_r     <= 1'b1;
    end else if (wr_status_s && WD[STAT_CAP]) begin
      capture_r <= capture_r;
      cap_r     <= 1'b0;
    end else begin
      capture_r <= capture_r;
      cap_r     <= cap_r;
    end
  end

  assign cap_flag_s = cap_r;
  assign capture_s  = capture_r;
`else
  assign cap_flag_s = 1'b0;
  assign capture_s  = 32'h0;
`endif

  // Read mux over the register window; unused offsets read zero
  always_comb begin
    rd_mux_s = 32'h0;
    case (off_s)
      OFF_CTRL:    rd_mux_s = {29'h0, ctrl_irqen_r, ctrl_auto_r, ctrl_en_r};
      OFF_PRESC:   rd_mux_s = {{(32-PRESC_W){1'b0}}, presc_r};
      OFF_COUNT:   rd_mux_s = count_r;
      OFF_CMP:     rd_mux_s = cmp_r;
      OFF_STATUS:  rd_mux_s = {30'h0, cap_flag_s, match_r};
      OFF_CAPTURE: rd_mux_s = capture_s;
      default:     rd_mux_s = 32'h0;
    endcase
  end

  assign RD  = (sel_s && RE) ? rd_mux_s : 32'h0;
  assign irq = (match_r || cap_flag_s) && ctrl_irqen_r;

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer peripheral. It acts as the responder on the processor's data-memory bus (address, write data, write enable, read enable, read data) and sits in parallel with data RAM.
- Software uses load/store to program a prescaled 32-bit up-counter, a compare value and a match flag. Match raises an interrupt line.
- Read data is zero when the block is not selected, so the top level can OR it with RAM read data.

Parameters:
- ADDR_W, 10, width of byte address input A.
- BASE_ADDR, 10'h3E0, base of 32-byte register window; decode compares A[ADDR_W-1:5] with BASE_ADDR[ADDR_W-1:5].
- PRESC_W, 16, prescaler register width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- A  in  ADDR_W  byte address from the processor ALU result; A[1:0] ignored (word access only).
- WE  in  1  store strobe; write takes effect at the clk edge.
- RE  in  1  load strobe.
- WD  in  32  store data.
- RD  out  32  load data; combinational, valid in the same cycle as RE.
- irq  out  1  interrupt request, level.

Behaviour:
- sel = (A[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]).
- Register offsets (A[4:2]):
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 PRESC: low PRESC_W bits.
  - 0x08 COUNT: 32 bits.
  - 0x0C CMP: 32 bits.
  - 0x10 STATUS: bit0 MATCH, write-1-to-clear.
  - 0x14–0x1C: read 0, writes ignored.
- RD = register at offset when (sel & RE), else 32'h0.
- Write occurs when (sel & WE) at the clk edge. WE and RE together is legal: RD shows the pre-write value.
- Reset (reset_n=0 at edge): CTRL, PRESC, COUNT, CMP, STATUS and the prescaler counter all become 0. irq=0 and RD=0 in the following cycle. Reset mid-count discards all progress.
- Prescaler:
  - pre_cnt counts 0..PRESC while EN=1. tick=1 in the cycle where pre_cnt==PRESC, then pre_cnt returns to 0.
  - PRESC=0 gives a tick every cycle.
  - EN=0 holds pre_cnt at 0.
  - Writing PRESC resets pre_cnt to 0.
- Counter, on EN & tick:
  - If COUNT==CMP: MATCH<=1. COUNT<=0 if AUTO_RELOAD, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1, wrapping from 32'hFFFF_FFFF to 0 without setting MATCH unless CMP matches.
  - Latency: with PRESC=0 and COUNT==CMP at edge N, MATCH and irq are high after edge N.
- Simultaneous events:
  - Software write to COUNT beats the increment/reload in the same cycle.
  - A hardware MATCH set beats a W1C clear in the same cycle.
  - A CTRL write clearing EN takes effect at that edge, so no increment happens on that edge.
- irq = STATUS.MATCH & CTRL.IRQ_EN, combinational from registers (glitch-free).

Optional Feature:
- Macro TIMER_CAPTURE_EN.
- When defined:
  - Adds input port capture_in (1 bit, asynchronous), passed through a 2-flop synchronizer reset to 0.
  - A synchronized rising edge latches the current COUNT into CAPTURE (offset 0x14, read-only, reset 0) and sets STATUS bit1 CAP (W1C, set beats clear).
  - irq becomes (MATCH | CAP) & IRQ_EN.
- When undefined: no capture_in port, 0x14 reads 0, and STATUS bit1 reads 0.

Decomposition:
- Package mmio_timer_pkg holds:
  - register offset constants OFF_CTRL, OFF_PRESC, OFF_COUNT, OFF_CMP, OFF_STATUS, OFF_CAPTURE;
  - bit indices CTRL_EN, CTRL_AUTO, CTRL_IRQEN, STAT_MATCH, STAT_CAP.
- One sub-module, timer_prescaler (inputs clk, reset_n, en, presc, presc_wr; output tick).
- Register file, decode and counter logic stay in mmio_timer.

Test Plan:
- Reset with all registers pre-written nonzero → every register reads 0, irq=0, RD=0 with RE=0.
- Write PRESC=0, CMP=5, CTRL=0x5 (EN, IRQ_EN) → COUNT reads 1,2,… each cycle; irq rises one edge after COUNT==5; COUNT continues to 6. Write STATUS=1 → irq=0.
- PRESC=3, CTRL=0x3 (EN, AUTO), CMP=2 → COUNT increments every 4 cycles and sequences 0,1,2,0. MATCH is set at the 2→0 transition.
- COUNT=32'hFFFF_FFFF, CMP=7, EN → COUNT wraps to 0 with MATCH=0.
- Store to COUNT=100 in the same cycle as a tick → reads 100, not 101. W1C to STATUS in the same cycle as a match → MATCH stays 1.
- Load from A=BASE_ADDR+0x18 → RD=0. Load from A outside the window → RD=0. Store outside the window → no register changes. With TIMER_CAPTURE_EN: pulse capture_in at COUNT=40 → CAPTURE reads within 40..42 (synchronizer delay), and STATUS bit1=1.
